// File: rtl/icache_control.sv
// Sequencing controller for a two-way, 8-set instruction cache: hit/miss decision,
// LRU victim fill over a 256-bit pmem line read, and saturating hit/miss counters.
module icache_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmem_read_i,
    output logic        cmem_resp_o,
    input  logic        hit_i,
    input  logic        hit_way_1_i,
    input  logic        lru_way_i,
    output logic        way_select_o,
    output logic        cache_write_o,
    output logic        valid_bit_datain_o,
    output logic        unleash_cmem_rdata_o,
    output logic        pmem_read_o,
    input  logic        pmem_resp_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StFetch
    } state_e;

    state_e      state_q, state_d;
    logic        victim_q, victim_d;
    logic        abandon_q, abandon_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        hit_event, miss_event;

    always_comb begin
        state_d              = state_q;
        victim_d             = victim_q;
        abandon_d            = abandon_q;
        cmem_resp_o          = 1'b0;
        unleash_cmem_rdata_o = 1'b0;
        cache_write_o        = 1'b0;
        valid_bit_datain_o   = 1'b0;
        pmem_read_o          = 1'b0;
        way_select_o         = hit_way_1_i;
        hit_event            = 1'b0;
        miss_event           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmem_read_i) begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (!cmem_read_i) begin
                    state_d = StIdle;
                end else if (hit_i) begin
                    cmem_resp_o          = 1'b1;
                    unleash_cmem_rdata_o = 1'b1;
                    hit_event            = 1'b1;
                    state_d              = StIdle;
                end else begin
                    victim_d   = lru_way_i;
                    abandon_d  = 1'b0;
                    miss_event = 1'b1;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                pmem_read_o  = 1'b1;
                way_select_o = victim_q;
                // A dropped request still completes the fill but skips the replay.
                if (!cmem_read_i) begin
                    abandon_d = 1'b1;
                end
                if (pmem_resp_i) begin
                    cache_write_o      = 1'b1;
                    valid_bit_datain_o = 1'b1;
                    state_d            = (cmem_read_i && !abandon_q) ? StLookup : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!rst_n) begin
            way_select_o = 1'b0;
        end
    end

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_event && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_event && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            victim_q     <= 1'b0;
            abandon_q    <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            abandon_q    <= abandon_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;

endmodule

// File: tb/tb_icache_control.sv
// Randomized scoreboard bench for icache_control: emulates the two-way datapath and pmem,
// predicts fills/responses from a set-associative cache model, checks timing and counters.
module tb_icache_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmem_read = 1'b0;
    logic        pmem_resp = 1'b0;
    logic [31:0] cmem_address = '0;
    logic        hit, hit_way_1, lru_way;
    logic        cmem_resp, way_select, cache_write, valid_bit_datain;
    logic        unleash_cmem_rdata, pmem_read;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    icache_control dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmem_read_i          (cmem_read),
        .cmem_resp_o          (cmem_resp),
        .hit_i                (hit),
        .hit_way_1_i          (hit_way_1),
        .lru_way_i            (lru_way),
        .way_select_o         (way_select),
        .cache_write_o        (cache_write),
        .valid_bit_datain_o   (valid_bit_datain),
        .unleash_cmem_rdata_o (unleash_cmem_rdata),
        .pmem_read_o          (pmem_read),
        .pmem_resp_i          (pmem_resp),
        .hit_count_o          (hit_count),
        .miss_count_o         (miss_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Datapath emulation: tag/valid/LRU arrays driven by the controller's strobes.
    logic [23:0] dp_tag   [2][8] = '{default: '0};
    logic        dp_valid [2][8] = '{default: 1'b0};
    logic        dp_lru   [8]    = '{default: 1'b0};
    logic        lru_flip = 1'b0;
    logic [2:0]  cur_set;
    logic        h0, h1;

    assign cur_set   = cmem_address[7:5];
    assign h0        = dp_valid[0][cur_set] && (dp_tag[0][cur_set] == cmem_address[31:8]);
    assign h1        = dp_valid[1][cur_set] && (dp_tag[1][cur_set] == cmem_address[31:8]);
    assign hit       = h0 | h1;
    assign hit_way_1 = h1;
    // lru_way wobbles while a fetch is outstanding; the latched victim must not follow it.
    assign lru_way   = dp_lru[cur_set] ^ lru_flip;

    always @(posedge clk) begin
        lru_flip <= pmem_read ? ~lru_flip : 1'b0;
        if (cache_write) begin
            dp_tag[way_select][cur_set]   <= cmem_address[31:8];
            dp_valid[way_select][cur_set] <= valid_bit_datain;
        end
        if (cmem_resp) begin
            dp_lru[cur_set] <= ~way_select;
        end
    end

    // Physical memory: pmem_resp in the pmem_n-th consecutive cycle of pmem_read.
    int pmem_n = 1;
    int pcnt   = 0;
    always @(posedge clk) begin
        #1;
        if (pmem_read) begin
            pcnt      = pcnt + 1;
            pmem_resp = (pcnt == pmem_n);
        end else begin
            pcnt      = 0;
            pmem_resp = 1'b0;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic fill;
        logic way;
        int   off;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   req_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (cache_write || cmem_resp)) begin
            chk("write_resp_exclusive", {63'd0, cache_write & cmem_resp}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {62'd0, cache_write, cmem_resp}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", {63'd0, cache_write}, {63'd0, mon_e.fill});
                chk("event_way", {63'd0, way_select}, {63'd0, mon_e.way});
                chk("event_cycle", 64'(cyc - req_cyc), 64'(mon_e.off));
                if (mon_e.fill) chk("fill_valid_bit", {63'd0, valid_bit_datain}, 64'd1);
                else chk("resp_unleash", {63'd0, unleash_cmem_rdata}, 64'd1);
            end
        end
    end

    // Reference model: two-way set-associative cache, 32-byte lines, bit 1 = way 0 most recent.
    logic [23:0] rt [2][8];
    logic        rv [2][8];
    logic        rl [8];
    longint      ref_hit = 0;
    longint      ref_miss = 0;

    function automatic int ref_lookup(input logic [31:0] a);
        for (int w = 0; w < 2; w++) begin
            if (rv[w][a[7:5]] && (rt[w][a[7:5]] == a[31:8])) return w;
        end
        return -1;
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    function automatic exp_t mk(input logic fill, input logic way, input int off);
        exp_t e;
        e.fill = fill;
        e.way  = way;
        e.off  = off;
        return e;
    endfunction

    task automatic check_counts();
        chk("hit_count", {32'd0, hit_count}, ref_hit);
        chk("miss_count", {32'd0, miss_count}, ref_miss);
    endtask

    // Full fetch: predicts hit (response one cycle after IDLE) or miss (fill, then replay hit).
    task automatic issue(input logic [31:0] a, input int n);
        int   w, k;
        logic v;
        logic [2:0] s;
        s = a[7:5];
        w = ref_lookup(a);
        if (w >= 0) begin
            exp_q.push_back(mk(1'b0, w[0], 1));
            rl[s]   = (w == 0);
            ref_hit = sat_inc(ref_hit);
        end else begin
            v = rl[s];
            exp_q.push_back(mk(1'b1, v, n + 1));
            exp_q.push_back(mk(1'b0, v, n + 2));
            rt[v][s] = a[31:8];
            rv[v][s] = 1'b1;
            rl[s]    = ~v;
            ref_miss = sat_inc(ref_miss);
            ref_hit  = sat_inc(ref_hit);
        end
        pmem_n       = n;
        req_cyc      = cyc;
        cmem_address = a;
        cmem_read    = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmem_resp && k < 300);
        chk("resp_seen", {63'd0, cmem_resp}, 64'd1);
        @(posedge clk);
        #1;
        cmem_read = 1'b0;
    endtask

    // Miss whose request is withdrawn once the fetch starts: line still filled, no response.
    task automatic abandon(input logic [31:0] a, input int n);
        int   k;
        logic v;
        logic [2:0] s;
        s = a[7:5];
        v = rl[s];
        exp_q.push_back(mk(1'b1, v, n + 1));
        rt[v][s] = a[31:8];
        rv[v][s] = 1'b1;
        ref_miss = sat_inc(ref_miss);
        pmem_n       = n;
        req_cyc      = cyc;
        cmem_address = a;
        cmem_read    = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!pmem_read && k < 10);
        chk("fetch_entered", {63'd0, pmem_read}, 64'd1);
        cmem_read = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (pmem_read && k < 300);
        chk("fetch_left", {63'd0, pmem_read}, 64'd0);
    endtask

    // Request withdrawn in LOOKUP: no response, no count.
    task automatic pulse(input logic [31:0] a);
        cmem_address = a;
        cmem_read    = 1'b1;
        @(posedge clk);
        #1;
        cmem_read = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        int          k, kind, n;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 8; s++) begin
                rt[w][s] = '0;
                rv[w][s] = 1'b0;
            end
        end
        for (int s = 0; s < 8; s++) rl[s] = 1'b0;

        cmem_address = 32'h0000_1000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pmem_read", {63'd0, pmem_read}, 64'd0);
        chk("rst_cmem_resp", {63'd0, cmem_resp}, 64'd0);
        rst_n = 1'b1;
        check_counts();

        // Reset asserted mid-fetch
        pmem_n    = 50;
        cmem_read = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!pmem_read && k < 10);
        chk("mid_fetch_pmem_read", {63'd0, pmem_read}, 64'd1);
        chk("mid_fetch_miss_count", {32'd0, miss_count}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_drop_pmem_read", {63'd0, pmem_read}, 64'd0);
        chk("rst_cache_write", {63'd0, cache_write}, 64'd0);
        chk("rst_unleash", {63'd0, unleash_cmem_rdata}, 64'd0);
        cmem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_counts();

        // Directed: cold miss, victim from LRU, hits on both ways, abandoned fill
        issue(32'h0000_0040, 4);
        check_counts();
        issue(32'h0000_1040, 3);
        issue(32'h0000_1040, 1);
        issue(32'h0000_0040, 1);
        abandon(32'h0000_2040, 2);
        issue(32'h0000_2040, 1);
        check_counts();

        // way_select follows hit_way_1 in IDLE and is forced low under reset
        #1;
        chk("idle_way_select", {63'd0, way_select}, (ref_lookup(cmem_address) == 1) ? 64'd1 : 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_way_select", {63'd0, way_select}, 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ref_hit  = 0;
        ref_miss = 0;
        check_counts();

        for (int i = 0; i < 200; i++) begin
            a    = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 7)) << 5)
                 | ($urandom & 32'h1F);
            kind = int'($urandom_range(0, 9));
            n    = int'($urandom_range(1, 6));
            if (kind == 0) pulse(a);
            else if (kind == 1 && ref_lookup(a) < 0) abandon(a, n);
            else issue(a, n);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            check_counts();
        end

        // Saturation of the hit counter
        issue(32'h0000_0040, 2);
        force dut.hit_count_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.hit_count_q;
        ref_hit = 64'hFFFF_FFFE;
        chk("hit_preload", {32'd0, hit_count}, ref_hit);
        repeat (3) issue(32'h0000_0040, 1);
        check_counts();

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_control.md
# icache_control

Sequencing controller for the two-way, 8-set instruction-cache datapath (`I_cache_datapath`). It accepts CPU fetch requests on the cmem side and decides hit or miss from the datapath's tag/valid compare. On a miss it selects a victim way from the per-set LRU bit, issues a 256-bit line read on the pmem side and fills the line, then replays the lookup. It also keeps saturating hit/miss performance counters for the fetch path.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmem_read  in  1  CPU fetch request; held high, with cmem_address stable, until cmem_resp.
- cmem_resp  out  1  one-cycle fetch completion; also drives the datapath LRU write.
- hit  in  1  datapath: either way tag-match and valid.
- hit_way_1  in  1  datapath: way 1 matched.
- lru_way  in  1  datapath: stored LRU bit for the current set (1 = way 0 most recent, so victim is way 1).
- way_select  out  1  datapath way mux/decoder select.
- cache_write  out  1  datapath write strobe for the data, tag and valid arrays of the selected way.
- valid_bit_datain  out  1  valid bit written on fill.
- unleash_cmem_rdata  out  1  load strobe for the datapath read-data holding registers.
- pmem_read  out  1  line read request to physical memory.
- pmem_resp  in  1  physical memory: pmem_rdata valid this cycle only.
- hit_count  out  32  saturating count of hit completions.
- miss_count  out  32  saturating count of misses (fill starts).

## Operation
- States: IDLE, LOOKUP, FETCH. Reset state is IDLE.
- IDLE: all strobes low. cmem_read=1 moves to LOOKUP next edge. cmem_read=0 stays in IDLE.
- LOOKUP:
  - hit=1: cmem_resp=1 and unleash_cmem_rdata=1, both combinational, with way_select=hit_way_1. hit_count increments. Next state is IDLE.
  - hit=0: victim register <= lru_way and miss_count increments. Next state is FETCH.
  - cmem_read=0 in LOOKUP: no response, no count change. Next state is IDLE.
- FETCH:
  - pmem_read=1 and way_select=victim.
  - While pmem_resp=0, stay in FETCH.
  - In the pmem_resp=1 cycle: cache_write=1 and valid_bit_datain=1, both combinational, so the fill captures pmem_rdata that cycle. Next state is LOOKUP, where the replay hits.
- cmem_read dropping during FETCH does not abort the fill. After the fill the next state is IDLE instead of LOOKUP.
- way_select default: hit_way_1 in IDLE/LOOKUP, victim in FETCH.
- Counters are 32-bit and saturate at 0xFFFF_FFFF with no wrap.
- Never assert cache_write and cmem_resp in the same cycle.

## Timing
- Reset values, applied asynchronously: state IDLE, victim 0, hit_count 0, miss_count 0.
- With rst_n low, every combinational output is low: cmem_resp, cache_write, valid_bit_datain, unleash_cmem_rdata, pmem_read. way_select is 0.
- Reset during FETCH drops pmem_read immediately. The line is not written. Memory must tolerate an abandoned request.
- Hit latency: request seen in IDLE at cycle 0, cmem_resp in cycle 1 (2 cycles request-to-response).
- Miss latency, where N = cycles from pmem_read rising to pmem_resp (N>=1):
  - cycle 1: LOOKUP (miss)
  - cycles 2..N+1: FETCH
  - cycle N+2: LOOKUP (hit, cmem_resp)
  - Total is N+3 cycles.
- Back-to-back fetches: after cmem_resp the controller spends one cycle in IDLE. The next request is responded to no earlier than 2 cycles later.
- pmem_read stays high continuously from FETCH entry through the pmem_resp cycle inclusive, then falls.

## Test plan
- Reset: hold rst_n=0 mid-FETCH with pmem_resp=0 -> pmem_read drops the same cycle; after release, state IDLE and both counters 0.
- Cold miss, addr 0x0000_0040, lru_way=0, pmem_resp after 4 cycles:
  - pmem_read high for 4 cycles.
  - One cache_write with way_select=0 and valid_bit_datain=1.
  - cmem_resp 7 cycles after the request.
  - miss_count=1, hit_count=1.
- Hit on way 1 (hit=1, hit_way_1=1): cmem_resp and unleash_cmem_rdata are high for exactly 1 cycle with way_select=1; pmem_read never rises; hit_count +1.
- Victim selection: miss with lru_way=1 -> cache_write with way_select=1; lru_way toggling during FETCH does not change way_select.
- Abandon: drop cmem_read in FETCH, then pmem_resp=1 -> the fill still writes (cache_write=1), no cmem_resp, next state IDLE.
- Saturation: preload hit_count to 0xFFFF_FFFE, then 3 hits -> value 0xFFFF_FFFF, no wrap.
